// File: rtl/channel_pkg.sv
// Shared constants, state encoding and random-draw helpers for the channel
// traffic generator and its LFSR.
package channel_pkg;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          DLY_W        = 8;

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_GAP,
        SRC_SEND
    } src_state_e;

    // Ranged draw: lo + (r8 mod (hi - lo + 1)).
    function automatic logic [DLY_W-1:0] rand_range(logic [7:0] r8, int lo, int hi);
        int span;
        span = hi - lo + 1;
        return DLY_W'(lo + int'(r8) % span);
    endfunction

    function automatic logic [15:0] rot16(logic [15:0] x, int k);
        return (x >> k) | (x << (16 - k));
    endfunction

endpackage

// File: rtl/channel_traffic_gen_if.sv
// Handshake channel interfaces: Channel (valid/ack) and PassiveChannel
// (ready/valid-pulse), each with master and slave views.
interface Channel #(parameter int N = 8);
    logic [N-1:0] d;
    logic         v;
    logic         a;

    modport master (output d, output v, input a);
    modport slave  (input d, input v, output a);
endinterface

interface PassiveChannel #(parameter int N = 8);
    logic [N-1:0] d;
    logic         v;
    logic         r;

    modport master (output d, output v, input r);
    modport slave  (input d, input v, output r);
endinterface

// File: rtl/channel_lfsr.sv
// 16-bit Galois LFSR, shifting right every cycle; reset loads Seed.
module channel_lfsr
    import channel_pkg::*;
#(
    parameter logic [15:0] Seed = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = {1'b0, state_q[15:1]};
        if (state_q[0]) state_d = state_d ^ LFSR_POLY;
    end

    // NOTE: registers use <= so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= Seed;
        else        state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/channel_traffic_gen.sv
// Pseudo-random traffic sources and backpressuring, checksumming sinks for
// Channel and PassiveChannel links; one shared LFSR feeds all draws.
module channel_traffic_gen
    import channel_pkg::*;
#(
    parameter int           N         = 8,
    parameter logic [N-1:0] Mask      = '1,
    parameter int           SrcDlyMin = 0,
    parameter int           SrcDlyMax = 5,
    parameter int           SnkDlyMin = 0,
    parameter int           SnkDlyMax = 5,
    parameter logic [15:0]  Seed      = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    Channel.master        src,
    Channel.slave         snk,
    PassiveChannel.master psrc,
    PassiveChannel.slave  psnk,
    output logic [31:0]   src_cnt,
    output logic [31:0]   snk_cnt,
    output logic [31:0]   psrc_cnt,
    output logic [31:0]   psnk_cnt,
    output logic [N-1:0]  snk_sum,
    output logic [N-1:0]  psnk_sum
);

    localparam int REP = (N + 15) / 16;

    logic [15:0] lfsr;

    channel_lfsr #(.Seed(Seed)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .state_o (lfsr)
    );

    // Each consumer sees the LFSR through its own rotation.
    logic [DLY_W-1:0] src_dly_r, snk_dly_r, psrc_dly_r, psnk_dly_r;
    logic [N-1:0]     src_rand, psrc_rand;

    assign src_dly_r  = rand_range(8'(rot16(lfsr, 0)), SrcDlyMin, SrcDlyMax);
    assign snk_dly_r  = rand_range(8'(rot16(lfsr, 4)), SnkDlyMin, SnkDlyMax);
    assign psrc_dly_r = rand_range(8'(rot16(lfsr, 2)), SrcDlyMin, SrcDlyMax);
    assign psnk_dly_r = rand_range(8'(rot16(lfsr, 6)), SnkDlyMin, SnkDlyMax);
    assign src_rand   = N'({REP{rot16(lfsr, 8)}}) & Mask;
    assign psrc_rand  = N'({REP{rot16(lfsr, 12)}}) & Mask;

    // ---------------- Channel source ----------------
    src_state_e       src_state_q, src_state_d;
    logic [DLY_W-1:0] src_dly_q, src_dly_d;
    logic [N-1:0]     src_data_q, src_data_d;
    logic             src_v_q, src_v_d;
    logic [31:0]      src_cnt_q, src_cnt_d;
    logic             src_xfer;

    assign src_xfer = src_v_q & src.a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_state_q <= SRC_IDLE;
            src_dly_q   <= '0;
            src_data_q  <= '0;
            src_v_q     <= 1'b0;
            src_cnt_q   <= '0;
        end else begin
            src_state_q <= src_state_d;
            src_dly_q   <= src_dly_d;
            src_data_q  <= src_data_d;
            src_v_q     <= src_v_d;
            src_cnt_q   <= src_cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        src_state_d = src_state_q;
        src_dly_d   = src_dly_q;
        src_data_d  = src_data_q;
        src_v_d     = src_v_q;
        src_cnt_d   = src_cnt_q;
        unique case (src_state_q)
            SRC_IDLE: begin
                if (en) begin
                    src_dly_d   = src_dly_r;
                    src_state_d = SRC_GAP;
                end
            end
            SRC_GAP: begin
                if (!en) begin
                    src_state_d = SRC_IDLE;
                end else if (src_dly_q == '0) begin
                    src_v_d     = 1'b1;
                    src_data_d  = src_rand;
                    src_state_d = SRC_SEND;
                end else begin
                    src_dly_d = src_dly_q - DLY_W'(1);
                end
            end
            SRC_SEND: begin
                if (src_xfer) begin
                    src_cnt_d = src_cnt_q + 32'd1;
                    src_dly_d = src_dly_r;
                    if (!en) begin
                        src_v_d     = 1'b0;
                        src_state_d = SRC_IDLE;
                    end else if (src_dly_r == '0) begin
                        src_data_d = src_rand;
                    end else begin
                        src_v_d     = 1'b0;
                        src_state_d = SRC_GAP;
                    end
                end
            end
            default: src_state_d = SRC_IDLE;
        endcase
    end

    always_comb begin
        src.v   = src_v_q;
        src.d   = src_data_q;
        src_cnt = src_cnt_q;
    end

    // ---------------- Channel sink ----------------
    logic [DLY_W-1:0] snk_busy_q;
    logic [31:0]      snk_cnt_q;
    logic [N-1:0]     snk_sum_q;
    logic             snk_xfer;

    assign snk.a    = snk.v & (snk_busy_q == '0);
    assign snk_xfer = snk.v & snk.a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snk_busy_q <= '0;
            snk_cnt_q  <= '0;
            snk_sum_q  <= '0;
        end else if (snk_xfer) begin
            snk_busy_q <= snk_dly_r;
            snk_cnt_q  <= snk_cnt_q + 32'd1;
            snk_sum_q  <= snk_sum_q ^ snk.d;
        end else if (snk_busy_q != '0) begin
            snk_busy_q <= snk_busy_q - DLY_W'(1);
        end
    end

    assign snk_cnt = snk_cnt_q;
    assign snk_sum = snk_sum_q;

    // ---------------- PassiveChannel source ----------------
    logic [DLY_W-1:0] psrc_gap_q;
    logic [N-1:0]     psrc_data_q;
    logic             psrc_v_q;
    logic [31:0]      psrc_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psrc_gap_q  <= '0;
            psrc_data_q <= '0;
            psrc_v_q    <= 1'b0;
            psrc_cnt_q  <= '0;
        end else if (psrc.r && en && psrc_gap_q == '0) begin
            psrc_gap_q  <= psrc_dly_r;
            psrc_data_q <= psrc_rand;
            psrc_v_q    <= 1'b1;
            psrc_cnt_q  <= psrc_cnt_q + 32'd1;
        end else begin
            psrc_v_q <= 1'b0;
            if (psrc_gap_q != '0) psrc_gap_q <= psrc_gap_q - DLY_W'(1);
        end
    end

    assign psrc.v   = psrc_v_q;
    assign psrc.d   = psrc_data_q;
    assign psrc_cnt = psrc_cnt_q;

    // ---------------- PassiveChannel sink ----------------
    // A pulse is always taken, even with r low: the source may fire once more
    // in the cycle r falls.
    logic [DLY_W-1:0] psnk_busy_q, psnk_busy_d;
    logic             psnk_r_q;
    logic [31:0]      psnk_cnt_q;
    logic [N-1:0]     psnk_sum_q;

    always_comb begin
        psnk_busy_d = psnk_busy_q;
        if (psnk.v)                  psnk_busy_d = psnk_dly_r;
        else if (psnk_busy_q != '0)  psnk_busy_d = psnk_busy_q - DLY_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psnk_busy_q <= '0;
            psnk_r_q    <= 1'b1;
            psnk_cnt_q  <= '0;
            psnk_sum_q  <= '0;
        end else begin
            psnk_busy_q <= psnk_busy_d;
            psnk_r_q    <= (psnk_busy_d == '0);
            if (psnk.v) begin
                psnk_cnt_q <= psnk_cnt_q + 32'd1;
                psnk_sum_q <= psnk_sum_q ^ psnk.d;
            end
        end
    end

    assign psnk.r   = psnk_r_q;
    assign psnk_cnt = psnk_cnt_q;
    assign psnk_sum = psnk_sum_q;

endmodule

// File: tb/tb_channel_traffic_gen.sv
// Bench for channel_traffic_gen: three instances with different delay/mask
// settings, loopback monitors and a scoreboard on a bench-driven sink.
module tb_channel_traffic_gen;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2, en0, en1, en2;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- u0: all delays 0, full loopback ----------------
    Channel #(N)        u0_src ();
    Channel #(N)        u0_snk ();
    PassiveChannel #(N) u0_psrc ();
    PassiveChannel #(N) u0_psnk ();
    logic [31:0]  u0_src_cnt, u0_snk_cnt, u0_psrc_cnt, u0_psnk_cnt;
    logic [N-1:0] u0_snk_sum, u0_psnk_sum;

    assign u0_snk.d  = u0_src.d;
    assign u0_snk.v  = u0_src.v;
    assign u0_src.a  = u0_snk.a;
    assign u0_psnk.d = u0_psrc.d;
    assign u0_psnk.v = u0_psrc.v;
    assign u0_psrc.r = u0_psnk.r;

    channel_traffic_gen #(.SrcDlyMin(0), .SrcDlyMax(0), .SnkDlyMin(0), .SnkDlyMax(0)) u0 (
        .clk(clk), .reset(rst0), .en(en0),
        .src(u0_src), .snk(u0_snk), .psrc(u0_psrc), .psnk(u0_psnk),
        .src_cnt(u0_src_cnt), .snk_cnt(u0_snk_cnt), .psrc_cnt(u0_psrc_cnt), .psnk_cnt(u0_psnk_cnt),
        .snk_sum(u0_snk_sum), .psnk_sum(u0_psnk_sum)
    );

    int           u0_n = 0, u0_pn = 0;
    logic [N-1:0] u0_xor = '0, u0_pxor = '0, u0_pend_d = '0;
    logic         u0_pend = 1'b0;

    always @(negedge clk) begin
        if (u0_pend) begin
            u0_xor ^= u0_pend_d;
            u0_n++;
        end
        u0_pend   = rst0 && u0_src.v && u0_src.a;
        u0_pend_d = u0_src.d;
        if (rst0 && u0_psrc.v) begin
            u0_pxor ^= u0_psrc.d;
            u0_pn++;
        end
    end

    // ---------------- u1: sink 3..3, mask 0F ----------------
    Channel #(N)        u1_src ();
    Channel #(N)        u1_snk ();
    PassiveChannel #(N) u1_psrc ();
    PassiveChannel #(N) u1_psnk ();
    logic [31:0]  u1_src_cnt, u1_snk_cnt, u1_psrc_cnt, u1_psnk_cnt;
    logic [N-1:0] u1_snk_sum, u1_psnk_sum;

    assign u1_snk.d  = u1_src.d;
    assign u1_snk.v  = u1_src.v;
    assign u1_src.a  = u1_snk.a;
    assign u1_psnk.d = u1_psrc.d;
    assign u1_psnk.v = u1_psrc.v;
    assign u1_psrc.r = u1_psnk.r;

    channel_traffic_gen #(.Mask(8'h0F), .SrcDlyMin(0), .SrcDlyMax(0), .SnkDlyMin(3), .SnkDlyMax(3)) u1 (
        .clk(clk), .reset(rst1), .en(en1),
        .src(u1_src), .snk(u1_snk), .psrc(u1_psrc), .psnk(u1_psnk),
        .src_cnt(u1_src_cnt), .snk_cnt(u1_snk_cnt), .psrc_cnt(u1_psrc_cnt), .psnk_cnt(u1_psnk_cnt),
        .snk_sum(u1_snk_sum), .psnk_sum(u1_psnk_sum)
    );

    int           u1_cyc = 0, u1_last_a = -1, u1_acnt = 0, u1_bad_gap = 0;
    int           u1_nstall = 0, u1_bad_stab = 0, u1_bad_mask = 0, u1_nmask = 0;
    logic         u1_prev_stall = 1'b0;
    logic [N-1:0] u1_prev_d = '0;

    always @(negedge clk) begin
        if (rst1) begin
            if (u1_src.v && u1_src.a) begin
                if (u1_last_a >= 0 && u1_cyc - u1_last_a != 4) u1_bad_gap++;
                u1_last_a = u1_cyc;
                u1_acnt++;
            end
            if (u1_prev_stall && (!u1_src.v || u1_src.d !== u1_prev_d)) u1_bad_stab++;
            u1_prev_stall = u1_src.v && !u1_src.a;
            u1_prev_d     = u1_src.d;
            if (u1_prev_stall) u1_nstall++;
            if (u1_src.v || u1_psrc.v) u1_nmask++;
            if (u1_src.d >= 16 || u1_psrc.d >= 16) u1_bad_mask++;
            u1_cyc++;
        end else begin
            u1_last_a     = -1;
            u1_prev_stall = 1'b0;
        end
    end

    // ---------------- u2: psnk 2..2, bench-driven Channel sink ----------------
    Channel #(N)        u2_src ();
    Channel #(N)        u2_snk ();
    PassiveChannel #(N) u2_psrc ();
    PassiveChannel #(N) u2_psnk ();
    logic [31:0]  u2_src_cnt, u2_snk_cnt, u2_psrc_cnt, u2_psnk_cnt;
    logic [N-1:0] u2_snk_sum, u2_psnk_sum;
    logic [N-1:0] u2_snk_d;
    logic         u2_snk_v;

    assign u2_src.a  = 1'b1;
    assign u2_snk.d  = u2_snk_d;
    assign u2_snk.v  = u2_snk_v;
    assign u2_psnk.d = u2_psrc.d;
    assign u2_psnk.v = u2_psrc.v;
    assign u2_psrc.r = u2_psnk.r;

    channel_traffic_gen #(.SrcDlyMin(0), .SrcDlyMax(3), .SnkDlyMin(2), .SnkDlyMax(2), .Seed(16'h1D2B)) u2 (
        .clk(clk), .reset(rst2), .en(en2),
        .src(u2_src), .snk(u2_snk), .psrc(u2_psrc), .psnk(u2_psnk),
        .src_cnt(u2_src_cnt), .snk_cnt(u2_snk_cnt), .psrc_cnt(u2_psrc_cnt), .psnk_cnt(u2_psnk_cnt),
        .snk_sum(u2_snk_sum), .psnk_sum(u2_psnk_sum)
    );

    int           u2_vcnt = 0, u2_bad_r = 0, u2_npulse = 0;
    logic         u2_pv1 = 1'b0, u2_pv2 = 1'b0;
    logic [N-1:0] u2_q[$];
    logic [N-1:0] u2_exp_sum = '0;
    logic [31:0]  u2_cnt_prev = '0;
    int           u2_popped = 0;

    always @(negedge clk) begin
        if (rst2) begin
            if (u2_src.v || u2_psrc.v) u2_vcnt++;
            // r is low exactly in the two cycles following any pulse
            if (u2_psnk.r !== !(u2_pv1 || u2_pv2)) u2_bad_r++;
            u2_pv2 = u2_pv1;
            u2_pv1 = u2_psrc.v;
            if (u2_psrc.v) u2_npulse++;
            if (u2_snk_cnt != u2_cnt_prev) begin
                check("u2_sb_nonempty", u2_q.size() != 0, 1);
                if (u2_q.size() != 0) begin
                    u2_exp_sum ^= u2_q.pop_front();
                    u2_popped++;
                    check("u2_snk_sum", u2_snk_sum, u2_exp_sum);
                    check("u2_snk_cnt", u2_snk_cnt, u2_popped);
                end
            end
            u2_cnt_prev = u2_snk_cnt;
        end else begin
            u2_pv1 = 1'b0;
            u2_pv2 = 1'b0;
        end
    end

    // ---------------- Directed sequence ----------------
    logic [N-1:0] items [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h5A, 8'hC3};

    initial begin
        int w;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        en0  = 1'b0; en1  = 1'b0; en2  = 1'b0;
        u2_snk_v = 1'b0; u2_snk_d = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_src_v",    u0_src.v,    0);
        check("rst_psrc_v",   u0_psrc.v,   0);
        check("rst_src_d",    u0_src.d,    0);
        check("rst_psrc_d",   u0_psrc.d,   0);
        check("rst_psnk_r",   u0_psnk.r,   1);
        check("rst_counters", {u0_src_cnt, u0_snk_cnt} | {u0_psrc_cnt, u0_psnk_cnt}, 0);
        check("rst_sums",     {u0_snk_sum, u0_psnk_sum}, 0);

        @(negedge clk);
        rst0 = 1'b1; en0 = 1'b1;
        rst1 = 1'b1; en1 = 1'b1;
        rst2 = 1'b1;

        // 100 cycles of zero-delay loopback, then drain
        repeat (100) @(negedge clk);
        en0 = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("u0_src_cnt",   u0_src_cnt,  99);
        check("u0_snk_cnt",   u0_snk_cnt,  99);
        check("u0_logged_n",  u0_n,        99);
        check("u0_snk_sum",   u0_snk_sum,  u0_xor);
        check("u0_psrc_cnt",  u0_psrc_cnt, 100);
        check("u0_psnk_cnt",  u0_psnk_cnt, 100);
        check("u0_plogged_n", u0_pn,       100);
        check("u0_psnk_sum",  u0_psnk_sum, u0_pxor);

        // u1 has been running alongside
        check("u1_a_every_4", u1_bad_gap, 0);
        check("u1_a_seen",    u1_acnt > 20, 1);
        check("u1_d_stable",  u1_bad_stab, 0);
        check("u1_stalls",    u1_nstall > 40, 1);
        check("u1_mask",      u1_bad_mask, 0);
        check("u1_mask_seen", u1_nmask > 20, 1);

        // reset while src.v=1 and snk.a=0
        w = 0;
        while (!(u1_src.v && !u1_snk.a) && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("u1_stall_found", w < 10, 1);
        #1 rst1 = 1'b0;
        #1;
        check("u1_rst_src_v",   u1_src.v,   0);
        check("u1_rst_psrc_v",  u1_psrc.v,  0);
        check("u1_rst_src_cnt", u1_src_cnt, 0);
        check("u1_rst_snk_cnt", u1_snk_cnt, 0);
        check("u1_rst_snk_sum", u1_snk_sum, 0);
        check("u1_rst_psnk_r",  u1_psnk.r,  1);

        // u2 has stayed disabled since reset
        check("u2_idle_v",    u2_vcnt, 0);
        check("u2_idle_cnts", {u2_src_cnt, u2_psrc_cnt}, 0);

        @(negedge clk);
        en2 = 1'b1;
        repeat (150) @(negedge clk);
        en2 = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("u2_psnk_eq_psrc", u2_psnk_cnt, u2_psrc_cnt);
        check("u2_pulses_seen",  u2_npulse > 20, 1);
        check("u2_pulse_cnt",    u2_psrc_cnt, u2_npulse);
        check("u2_psnk_r_shape", u2_bad_r, 0);

        // bench acts as a Channel source into u2's sink
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            u2_snk_d = items[i];
            u2_snk_v = 1'b1;
            u2_q.push_back(items[i]);
            #1;
            w = 0;
            while (!u2_snk.a && w < 10) begin
                @(negedge clk);
                #1;
                w++;
            end
            check("u2_snk_accept_wait", w < 10, 1);
        end
        @(negedge clk);
        u2_snk_v = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("u2_sb_drained",   u2_q.size(), 0);
        check("u2_snk_cnt_final", u2_snk_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
